// File: rtl/multicycle_controller.sv
// Multi-cycle main controller: sequences fetch, decode, execute, memory and write-back
// for the shared-memory datapath, with stall, memory wait timeout and retire counting.
module multicycle_controller #(
    parameter int unsigned OPCODE_W    = 6,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                stall,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                memready,
    output logic                irwrite,
    output logic                pcwrite,
    output logic                pcwritecond,
    output logic                iord,
    output logic                memread,
    output logic                memwrite,
    output logic                memtoreg,
    output logic                regwrite,
    output logic                regdst,
    output logic                alusrca,
    output logic                secontrol,
    output logic                comp_control,
    output logic                j_control,
    output logic                jal_control,
    output logic [1:0]          alusrcb,
    output logic [1:0]          pcsource,
    output logic [1:0]          aluop,
    output logic                illegal,
    output logic                memfault,
    output logic [3:0]          state,
    output logic [CNT_W-1:0]    instrcount
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'h00);
    localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'h02);
    localparam logic [OPCODE_W-1:0] OP_JAL  = OPCODE_W'(6'h03);
    localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'h04);
    localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(6'h05);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'h08);
    localparam logic [OPCODE_W-1:0] OP_ORI  = OPCODE_W'(6'h0D);
    localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'h23);
    localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'h2B);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEM_RD = 4'd4,
        S_MEM_WR = 4'd5,
        S_WB     = 4'd6,
        S_BRANCH = 4'd7,
        S_JUMP   = 4'd8
    } state_t;

    state_t              cur, nxt;
    logic [OPCODE_W-1:0] opreg, opreg_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
    logic                mem_wait, timeout, retire;
    logic                is_r, is_ori, is_lw, is_sw, is_bne, is_jal;

    assign is_r   = (opreg == OP_R);
    assign is_ori = (opreg == OP_ORI);
    assign is_lw  = (opreg == OP_LW);
    assign is_sw  = (opreg == OP_SW);
    assign is_bne = (opreg == OP_BNE);
    assign is_jal = (opreg == OP_JAL);

    assign state      = cur;
    assign instrcount = cnt;

    // State, latched opcode, retire counter and memory wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur      <= S_IDLE;
            opreg    <= '0;
            cnt      <= '0;
            wait_cnt <= '0;
        end else begin
            cur      <= nxt;
            opreg    <= opreg_nxt;
            cnt      <= cnt_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Next state and datapath controls
    always_comb begin
        nxt          = cur;
        opreg_nxt    = opreg;
        cnt_nxt      = cnt;
        wait_nxt     = wait_cnt;
        mem_wait     = 1'b0;
        timeout      = 1'b0;
        retire       = 1'b0;
        irwrite      = 1'b0;
        pcwrite      = 1'b0;
        pcwritecond  = 1'b0;
        iord         = 1'b0;
        memread      = 1'b0;
        memwrite     = 1'b0;
        memtoreg     = 1'b0;
        regwrite     = 1'b0;
        regdst       = 1'b0;
        alusrca      = 1'b0;
        secontrol    = 1'b0;
        comp_control = 1'b0;
        j_control    = 1'b0;
        jal_control  = 1'b0;
        alusrcb      = 2'd0;
        pcsource     = 2'd0;
        aluop        = 2'b00;
        illegal      = 1'b0;
        memfault     = 1'b0;

        case (cur)
            S_IDLE: begin
                if (enable) nxt = S_FETCH;
            end
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = 2'd1;
                aluop   = 2'b10;
                if (memready) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    nxt     = S_DECODE;
                end else begin
                    mem_wait = 1'b1;
                end
            end
            S_DECODE: begin
                alusrcb   = 2'd2;
                aluop     = 2'b10;
                opreg_nxt = opcode;
                case (opcode)
                    OP_R, OP_ORI, OP_ADDI, OP_LW, OP_SW: nxt = S_EXEC;
                    OP_BEQ, OP_BNE:                      nxt = S_BRANCH;
                    OP_J, OP_JAL:                        nxt = S_JUMP;
                    default: begin
                        illegal = 1'b1;
                        nxt     = S_FETCH;
                    end
                endcase
            end
            S_EXEC: begin
                alusrca = 1'b1;
                if (is_r) begin
                    alusrcb = 2'd0;
                    aluop   = 2'b00;
                end else if (is_ori) begin
                    alusrcb = 2'd2;
                    aluop   = 2'b01;
                end else begin
                    alusrcb   = 2'd2;
                    aluop     = 2'b10;
                    secontrol = 1'b1;
                end
                nxt = is_lw ? S_MEM_RD : (is_sw ? S_MEM_WR : S_WB);
            end
            S_MEM_RD: begin
                memread = 1'b1;
                iord    = 1'b1;
                if (memready) nxt = S_WB;
                else          mem_wait = 1'b1;
            end
            S_MEM_WR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
                if (memready) begin
                    nxt    = S_FETCH;
                    retire = 1'b1;
                end else begin
                    mem_wait = 1'b1;
                end
            end
            S_WB: begin
                regwrite = 1'b1;
                regdst   = is_r;
                memtoreg = !is_lw;
                nxt      = S_FETCH;
                retire   = 1'b1;
            end
            S_BRANCH: begin
                alusrca      = 1'b1;
                alusrcb      = 2'd0;
                aluop        = 2'b11;
                pcwritecond  = 1'b1;
                pcsource     = 2'd1;
                comp_control = is_bne;
                nxt          = S_FETCH;
                retire       = 1'b1;
            end
            S_JUMP: begin
                pcwrite     = 1'b1;
                pcsource    = 2'd2;
                j_control   = 1'b1;
                regwrite    = is_jal;
                jal_control = is_jal;
                memtoreg    = is_jal;
                nxt         = S_FETCH;
                retire      = 1'b1;
            end
            default: nxt = S_IDLE;
        endcase

        // Abandon the access once the wait limit is hit with no ready
        if ((MEM_TIMEOUT > 0) && mem_wait) begin
            if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
                timeout = 1'b1;
                nxt     = S_FETCH;
            end else begin
                wait_nxt = wait_cnt + WAIT_W'(1);
            end
        end
        if ((nxt != cur) || timeout) wait_nxt = '0;
        memfault = timeout;
        if (retire) cnt_nxt = cnt + CNT_W'(1);

        // Stall freezes all sequencing and suppresses every write strobe
        if (stall) begin
            nxt         = cur;
            opreg_nxt   = opreg;
            cnt_nxt     = cnt;
            wait_nxt    = wait_cnt;
            irwrite     = 1'b0;
            pcwrite     = 1'b0;
            pcwritecond = 1'b0;
            regwrite    = 1'b0;
            memwrite    = 1'b0;
            illegal     = 1'b0;
            memfault    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: an instruction-level sequencer drives
// opcodes, memory wait states, stalls and resets and predicts every cycle's outputs.
module tb_multicycle_controller;

    localparam int unsigned TO = 15;
    localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BR = 3, K_JMP = 4, K_ILL = 5;

    typedef struct packed {
        logic       irwrite, pcwrite, pcwritecond, iord, memread, memwrite, memtoreg;
        logic       regwrite, regdst, alusrca, secontrol, comp_control, j_control, jal_control;
        logic [1:0] alusrcb, pcsource, aluop;
        logic       illegal, memfault;
    } ctl_t;

    logic        clk = 1'b0;
    logic        rst_n, enable, stall, memready;
    logic [5:0]  opcode;
    logic [21:0] v1, v2;
    logic [3:0]  state1, state2;
    logic [15:0] cnt1;
    logic [1:0]  cnt2;

    int checks = 0;
    int errors = 0;
    int cnt    = 0;
    bit running = 1'b0;

    logic [5:0] legal_ops [9] = '{6'h00, 6'h0D, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};

    always #5 clk = ~clk;

    multicycle_controller #(.OPCODE_W(6), .CNT_W(16), .MEM_TIMEOUT(TO)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .stall(stall), .opcode(opcode),
        .memready(memready),
        .irwrite(v1[21]), .pcwrite(v1[20]), .pcwritecond(v1[19]), .iord(v1[18]),
        .memread(v1[17]), .memwrite(v1[16]), .memtoreg(v1[15]), .regwrite(v1[14]),
        .regdst(v1[13]), .alusrca(v1[12]), .secontrol(v1[11]), .comp_control(v1[10]),
        .j_control(v1[9]), .jal_control(v1[8]), .alusrcb(v1[7:6]), .pcsource(v1[5:4]),
        .aluop(v1[3:2]), .illegal(v1[1]), .memfault(v1[0]),
        .state(state1), .instrcount(cnt1)
    );

    // Narrow-counter instance shares all stimulus to exercise counter wrap
    multicycle_controller #(.OPCODE_W(6), .CNT_W(2), .MEM_TIMEOUT(TO)) u_dut_w2 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .stall(stall), .opcode(opcode),
        .memready(memready),
        .irwrite(v2[21]), .pcwrite(v2[20]), .pcwritecond(v2[19]), .iord(v2[18]),
        .memread(v2[17]), .memwrite(v2[16]), .memtoreg(v2[15]), .regwrite(v2[14]),
        .regdst(v2[13]), .alusrca(v2[12]), .secontrol(v2[11]), .comp_control(v2[10]),
        .j_control(v2[9]), .jal_control(v2[8]), .alusrcb(v2[7:6]), .pcsource(v2[5:4]),
        .aluop(v2[3:2]), .illegal(v2[1]), .memfault(v2[0]),
        .state(state2), .instrcount(cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    function automatic int kind(input logic [5:0] op);
        case (op)
            6'h00, 6'h0D, 6'h08: return K_ALU;
            6'h23:               return K_LW;
            6'h2B:               return K_SW;
            6'h04, 6'h05:        return K_BR;
            6'h02, 6'h03:        return K_JMP;
            default:             return K_ILL;
        endcase
    endfunction

    // Control table per state, excluding the input-dependent strobes
    function automatic ctl_t base_ctl(input int st, input logic [5:0] op);
        ctl_t c;
        c = '0;
        case (st)
            1: begin c.memread = 1; c.alusrcb = 2'd1; c.aluop = 2'b10; end
            2: begin c.alusrcb = 2'd2; c.aluop = 2'b10; end
            3: begin
                c.alusrca = 1;
                if (op == 6'h00)      begin c.alusrcb = 2'd0; c.aluop = 2'b00; end
                else if (op == 6'h0D) begin c.alusrcb = 2'd2; c.aluop = 2'b01; end
                else begin c.alusrcb = 2'd2; c.aluop = 2'b10; c.secontrol = 1; end
            end
            4: begin c.memread = 1; c.iord = 1; end
            5: begin c.memwrite = 1; c.iord = 1; end
            6: begin c.regwrite = 1; c.regdst = (op == 6'h00); c.memtoreg = (op != 6'h23); end
            7: begin
                c.alusrca = 1; c.aluop = 2'b11; c.pcwritecond = 1; c.pcsource = 2'd1;
                c.comp_control = (op == 6'h05);
            end
            8: begin
                c.pcwrite = 1; c.pcsource = 2'd2; c.j_control = 1;
                if (op == 6'h03) begin c.regwrite = 1; c.jal_control = 1; c.memtoreg = 1; end
            end
            default: ;
        endcase
        return c;
    endfunction

    function automatic ctl_t stalled(input ctl_t c);
        ctl_t r;
        r = c;
        r.irwrite = 0; r.pcwrite = 0; r.pcwritecond = 0; r.regwrite = 0; r.memwrite = 0;
        r.illegal = 0; r.memfault = 0;
        return r;
    endfunction

    // Check one cycle mid-period, then advance to just after the next rising edge
    task automatic cycle(input int st, input ctl_t exp);
        @(negedge clk);
        chk("state", 32'(state1), 32'(st));
        chk("state_w2", 32'(state2), 32'(st));
        chk("ctl", 32'(v1), 32'(exp));
        chk("ctl_w2", 32'(v2), 32'(exp));
        chk("count", 32'(cnt1), 32'(cnt) & 32'hFFFF);
        chk("count_w2", 32'(cnt2), 32'(cnt) & 32'h3);
        @(posedge clk);
        #1;
        if (running) enable = 1'($urandom);
    endtask

    task automatic maybe_stall(input int st, input ctl_t b, input int forced);
        int n;
        if (forced >= 0) n = forced;
        else n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
        for (int i = 0; i < n; i++) begin
            stall    = 1'b1;
            memready = 1'($urandom);
            cycle(st, stalled(b));
        end
        stall = 1'b0;
    endtask

    // Memory-handshake state: w wait cycles then ready, or a fault if w exceeds the limit
    task automatic mem_stage(input int st, input logic [5:0] op, input int w, output bit ok);
        ctl_t b, e;
        bit   done;
        b    = base_ctl(st, op);
        done = 1'b0;
        ok   = 1'b0;
        for (int i = 0; i <= int'(TO) && !done; i++) begin
            maybe_stall(st, b, -1);
            e = b;
            if (i == w) begin
                memready = 1'b1;
                if (st == 1) begin e.irwrite = 1; e.pcwrite = 1; end
                ok   = 1'b1;
                done = 1'b1;
            end else if (i == int'(TO)) begin
                memready   = 1'b0;
                e.memfault = 1;
                done       = 1'b1;
            end else begin
                memready = 1'b0;
            end
            cycle(st, e);
        end
    endtask

    task automatic reset_chk();
        rst_n = 1'b0;
        #1;
        chk("rst_state", 32'(state1), 32'd0);
        chk("rst_ctl", 32'(v1), 32'd0);
        chk("rst_count", 32'(cnt1), 32'd0);
        chk("rst_count_w2", 32'(cnt2), 32'd0);
        cnt = 0; running = 1'b0; stall = 1'b0; enable = 1'b0; memready = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_phase();
        running = 1'b0;
        enable  = 1'b0;
        repeat ($urandom_range(1, 3)) cycle(0, '0);
        stall  = 1'b1;
        enable = 1'b1;
        cycle(0, '0);
        stall = 1'b0;
        cycle(0, '0);
        running = 1'b1;
    endtask

    task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                             input int xs, input bit rst_mem);
        bit   ok;
        int   k;
        ctl_t e;
        k      = kind(op);
        opcode = 6'($urandom);
        mem_stage(1, op, fw, ok);
        if (!ok) mem_stage(1, op, int'($urandom_range(0, 2)), ok);
        opcode = op;
        maybe_stall(2, base_ctl(2, op), -1);
        e = base_ctl(2, op);
        if (k == K_ILL) e.illegal = 1;
        cycle(2, e);
        opcode = 6'($urandom);
        if (k == K_ILL) return;
        if (k == K_BR || k == K_JMP) begin
            maybe_stall(k == K_BR ? 7 : 8, base_ctl(k == K_BR ? 7 : 8, op), -1);
            cycle(k == K_BR ? 7 : 8, base_ctl(k == K_BR ? 7 : 8, op));
            cnt++;
            return;
        end
        maybe_stall(3, base_ctl(3, op), xs);
        cycle(3, base_ctl(3, op));
        if (k == K_SW) begin
            mem_stage(5, op, mw, ok);
            if (ok) cnt++;
            return;
        end
        if (k == K_LW) begin
            if (rst_mem) begin
                memready = 1'b0;
                cycle(4, base_ctl(4, op));
                reset_chk();
                idle_phase();
                return;
            end
            mem_stage(4, op, mw, ok);
            if (!ok) return;
        end
        maybe_stall(6, base_ctl(6, op), -1);
        cycle(6, base_ctl(6, op));
        cnt++;
    endtask

    function automatic int pick_wait();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 7) return int'($urandom_range(0, 2));
        if (r == 7) return int'(TO);
        if (r == 8) return int'(TO) + 1;
        return 5;
    endfunction

    initial begin
        logic [5:0] op;
        rst_n = 1'b1; enable = 1'b0; stall = 1'b0; memready = 1'b0; opcode = '0;
        #1;
        reset_chk();
        idle_phase();
        run_instr(6'h00, 0, 0, 0, 1'b0);
        run_instr(6'h23, 0, 3, 0, 1'b0);
        run_instr(6'h05, 0, 0, 0, 1'b0);
        run_instr(6'h03, 0, 0, 0, 1'b0);
        run_instr(6'h3F, 0, 0, 0, 1'b0);
        run_instr(6'h2B, 0, int'(TO) + 1, 0, 1'b0);
        run_instr(6'h08, 0, 0, 5, 1'b0);
        run_instr(6'h2B, 0, int'(TO), -1, 1'b0);
        run_instr(6'h0D, int'(TO) + 1, 0, -1, 1'b0);
        run_instr(6'h04, 1, 0, -1, 1'b0);
        run_instr(6'h02, 2, 0, -1, 1'b0);
        run_instr(6'h23, 0, 2, -1, 1'b1);
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) op = 6'($urandom);
            else op = legal_ops[$urandom_range(0, 8)];
            run_instr(op, pick_wait(), pick_wait(), -1,
                      (op == 6'h23) && ($urandom_range(0, 19) == 0));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
